// File: rtl/div_ctrl.sv
// Multicycle sequencer around the combinational signed array divider; handles /0 and INT_MIN/-1 locally.
// Optional single-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl #(
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   operand_1,
  input  logic [DATA_W-1:0]   operand_2,
  input  logic                cancel,
  output logic                ready,
  output logic                stall_req,
  output logic                valid,
  output logic [2*DATA_W-1:0] result,
  output logic                div_en,
  output logic [DATA_W-1:0]   div_op1,
  output logic [DATA_W-1:0]   div_op2,
  input  logic                div_done,
  input  logic [2*DATA_W-1:0] div_result
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SPEC, S_DONE} state_t;

  localparam logic [DATA_W-1:0] INT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MINUS_ONE = '1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                accept;
  logic                is_special;
  logic                ld_ops;
  logic                cap_div;
  logic                cap_spec;
  logic                hit;
  logic [2*DATA_W-1:0] spec_res;

`ifdef DIV_RESULT_CACHE_EN
  logic                tag_v;
  logic [DATA_W-1:0]   c_op1, c_op2;
  logic [2*DATA_W-1:0] c_res;
`endif

  assign accept     = start & ~cancel;
  assign is_special = (operand_2 == '0) || (operand_1 == INT_MIN && operand_2 == MINUS_ONE);

  // Special results are derived from the latched operands so they match what was accepted.
  assign spec_res = (div_op2 == '0) ? {div_op1, MINUS_ONE} : {{DATA_W{1'b0}}, INT_MIN};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_ops    = 1'b0;
    cap_div   = 1'b0;
    cap_spec  = 1'b0;
    hit       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          ld_ops = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
          hit = tag_v && (operand_1 == c_op1) && (operand_2 == c_op2);
`endif
          if (hit) begin
            state_nxt = S_DONE;
          end else if (is_special) begin
            state_nxt = S_SPEC;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (div_done) begin
          cap_div   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_SPEC: begin
        cap_spec  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Flush wins over everything, including a capture due this cycle.
    if (cancel) begin
      state_nxt = S_IDLE;
      cap_div   = 1'b0;
      cap_spec  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_op1 <= '0;
      div_op2 <= '0;
      result  <= '0;
    end else begin
      if (ld_ops) begin
        div_op1 <= operand_1;
        div_op2 <= operand_2;
      end
      if (cap_div) begin
        result <= div_result;
      end else if (cap_spec) begin
        result <= spec_res;
      end
`ifdef DIV_RESULT_CACHE_EN
      else if (hit) begin
        result <= c_res;
      end
`endif
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= 1'b0;
      c_op1 <= '0;
      c_op2 <= '0;
      c_res <= '0;
    end else if (cap_div || cap_spec) begin
      tag_v <= 1'b1;
      c_op1 <= div_op1;
      c_op2 <= div_op2;
      c_res <= cap_div ? div_result : spec_res;
    end
  end
`endif

  assign ready     = (state == S_IDLE);
  assign valid     = (state == S_DONE);
  assign div_en    = (state == S_WAIT);
  assign stall_req = ((state == S_IDLE) & accept) | (state == S_WAIT) | (state == S_SPEC);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural signed divider on the div_* side.
module tb_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        cancel;
  logic        ready;
  logic        stall_req;
  logic        valid;
  logic [63:0] result;
  logic        div_en;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_done;
  logic [63:0] div_result;

  int checks   = 0;
  int failures = 0;

  logic        last_v;
  logic [31:0] last_a, last_b;

  div_ctrl #(.DATA_W(32), .WAIT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operand_1(operand_1),
    .operand_2(operand_2), .cancel(cancel), .ready(ready), .stall_req(stall_req),
    .valid(valid), .result(result), .div_en(div_en), .div_op1(div_op1),
    .div_op2(div_op2), .div_done(div_done), .div_result(div_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural array divider: truncating signed division, remainder takes the dividend's sign.
  always_comb begin
    logic signed [31:0] q, r;
    q = '0;
    r = '0;
    if (div_op2 != 32'd0 && !(div_op1 == 32'h8000_0000 && div_op2 == 32'hFFFF_FFFF)) begin
      q = $signed(div_op1) / $signed(div_op2);
      r = $signed(div_op1) % $signed(div_op2);
    end
    div_result = {r, q};
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int lat_exp, lat, stalls;
    bit seen;
    lat_exp = ((b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 5;
`ifdef DIV_RESULT_CACHE_EN
    if (last_v && a == last_a && b == last_b) lat_exp = 1;
`endif
    @(negedge clk);
    start = 1'b1; operand_1 = a; operand_2 = b;
    #1 stalls = stall_req ? 1 : 0;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) begin
        seen = 1'b1;
        lat  = k;
        check({tag, "_result"}, result, exp);
      end else if (stall_req) begin
        stalls++;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(lat_exp));
    @(negedge clk);
    check({tag, "_valid_pulse_end"}, {62'd0, valid, ready}, {62'd0, 1'b0, 1'b1});
    last_v = 1'b1; last_a = a; last_b = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; div_done = 1'b1;
    operand_1 = '0; operand_2 = '0;
    last_v = 1'b0; last_a = '0; last_b = '0;

    // Reset state
    @(negedge clk);
    check("rst_flags", {60'd0, ready, valid, div_en, stall_req}, {60'd0, 4'b1000});
    check("rst_result", result, 64'd0);
    check("rst_ops", {div_op1, div_op2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start together with cancel is dropped and the operands stay put
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; operand_1 = 32'd55; operand_2 = 32'd5;
    #1 check("idle_cancel_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_state", {62'd0, ready, div_en}, {62'd0, 2'b10});
    check("idle_cancel_ops", {32'd0, div_op1}, 64'd0);

    do_div("d100_7", 32'd100, 32'd7, {32'd2, 32'd14});
    do_div("dm7_2", 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("d7_m2", 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
    do_div("d5_0", 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    do_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

    // Cancel in the second WAIT cycle
    @(negedge clk);
    start = 1'b1; operand_1 = 32'd100; operand_2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("cancel_in_wait", {63'd0, div_en}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_state", {62'd0, ready, div_en}, {62'd0, 2'b10});
    check("cancel_result_kept", result, {32'd0, 32'h8000_0000});
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid) bad++;
    end
    check("cancel_no_valid", 64'(bad), 64'd0);
    do_div("d9_3", 32'd9, 32'd3, {32'd0, 32'd3});

    // Asynchronous reset mid-WAIT
    @(negedge clk);
    start = 1'b1; operand_1 = 32'd100; operand_2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("arst_flags", {60'd0, ready, valid, div_en, stall_req}, {60'd0, 4'b1000});
    check("arst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_v = 1'b0;

    // div_done held low past the wait count
    div_done = 1'b0;
    @(negedge clk);
    start = 1'b1; operand_1 = 32'd100; operand_2 = 32'd7;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!stall_req || valid || !div_en || div_op1 != 32'd100 || div_op2 != 32'd7) bad++;
    end
    check("hold_wait", 64'(bad), 64'd0);
    div_done = 1'b1;
    @(negedge clk);
    check("hold_valid", {63'd0, valid}, 64'd1);
    check("hold_result", result, {32'd2, 32'd14});
    @(negedge clk);
    last_v = 1'b1; last_a = 32'd100; last_b = 32'd7;

    // Repeated operands: hit the cache when it is built in, full latency otherwise
    do_div("c100_8a", 32'd100, 32'd8, {32'd4, 32'd12});
    do_div("c100_7a", 32'd100, 32'd7, {32'd2, 32'd14});
    do_div("c100_7b", 32'd100, 32'd7, {32'd2, 32'd14});
    do_div("c100_8b", 32'd100, 32'd8, {32'd4, 32'd12});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
